pc_run_ctrl: RTL and testbench
==============================

Name: pc_run_ctrl

Overview:
- Program-counter register and run/halt controller for the single-cycle MIPS core.
- Sits directly upstream of the next-PC logic:
  - drives PC to the instruction ROM and to next-PC generation;
  - captures NextPC each retiring cycle;
  - consumes the halt flag (syscall with $v0=10) to stop the machine.
- Provides resume (GO), single-step, a retired-instruction counter and a commit enable that gates all architectural writes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_BITS, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
NextPC  input  32  next instruction address from next-PC logic
halt  input  1  halt request (syscall with $v0==10), combinational, same cycle
go  input  1  resume button level; synchronised upstream; edge-detected here
step_mode  input  1  1 = halt after every retired instruction
PC  output  32  current instruction address
commit  output  1  1 = current instruction retires this cycle; gates RegFile/DMEM writes and branch counters
running  output  1  1 = state RUN
retired  output  CNT_BITS  count of retired instructions
misalign  output  1  sticky flag: a NextPC with [1:0]!=0 was captured

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, PC=RESET_PC, retired=0, misalign=0, go_q=0, halt_cause=0.
  - Release is observed on the next clk edge.
- go_q <= go every cycle. go_edge = go & ~go_q.
- States: RUN, HALTED. halt_cause register: 0 = step, 1 = syscall.
- commit = (state==RUN) & ~halt. Combinational; no latency.
- RUN, halt=1:
  - next state HALTED, halt_cause=1.
  - PC unchanged, pointing at the syscall. retired unchanged.
- RUN, halt=0:
  - PC <= {NextPC[31:2],2'b00}.
  - retired <= retired+1, saturating at all-ones; no wrap.
  - If NextPC[1:0]!=0, misalign <= 1. misalign is cleared only by reset.
  - If step_mode=1: next state HALTED, halt_cause=0. Otherwise stay in RUN.
- HALTED:
  - commit=0, PC held, retired held.
  - On go_edge: state <= RUN.
    - halt_cause=1: PC <= PC+4 (skips the syscall; modulo 2^32, wrap 32'hFFFF_FFFC -> 0).
    - halt_cause=0: PC unchanged; it already points to the next instruction.
  - go held high produces only one resume.
- Edge cases:
  - go_edge in RUN is ignored (go_q still updates).
  - Step while halt=1: halt takes priority; halt_cause=1; PC not advanced.
  - step_mode changing while HALTED takes effect on the first cycle after resume.
  - Resume into an instruction that again raises halt: exactly one cycle in RUN with commit=0, then HALTED again.
  - Reset mid-HALTED or mid-RUN: immediate return to reset values; a pending go_edge is discarded.
- running = (state==RUN).
- All outputs come directly from registers, except commit.

Test Plan:
- Reset, then feed NextPC=PC+4 for 5 cycles with halt=0 -> PC steps 0,4,8,12,16,20; retired=5; commit=1 each cycle.
- At PC=0x20 assert halt=1 -> PC stays 0x20; running=0 next cycle; commit=0 during halt cycle; retired frozen. Then pulse go for 3 cycles -> single resume, PC=0x24, running=1.
- step_mode=1, NextPC=0x100 at PC=0x0 -> PC=0x100, HALTED, retired=1. go pulse -> RUN with PC still 0x100. Next cycle with NextPC=0x104 -> PC=0x104, HALTED again.
- NextPC=0x0000_0013 -> PC=0x10, misalign=1; stays 1 across further cycles until rst=0.
- Assert rst=0 asynchronously mid-cycle while HALTED with PC=0x40 -> PC=RESET_PC, retired=0, running=1 immediately, before the next clk edge.
- CNT_BITS=4: retire 20 instructions -> retired saturates at 4'hF.

Source files
------------

// File: rtl/pc_run_ctrl_if.sv
// Bus between the PC/run controller and the rest of the single-cycle core.
// The master side is the core (next-PC logic, syscall decode, front panel);
// the slave side is pc_run_ctrl itself.
interface pc_run_ctrl_if #(
  parameter int CNT_BITS = 32
);
  logic [31:0]         NextPC;
  logic                halt;
  logic                go;
  logic                step_mode;
  logic [31:0]         PC;
  logic                commit;
  logic                running;
  logic [CNT_BITS-1:0] retired;
  logic                misalign;

  modport master (
    output NextPC, halt, go, step_mode,
    input  PC, commit, running, retired, misalign
  );

  modport slave (
    input  NextPC, halt, go, step_mode,
    output PC, commit, running, retired, misalign
  );
endinterface

// File: rtl/pc_run_ctrl.sv
// Program counter and run/halt controller for the single-cycle MIPS core.
// Holds the PC, stops the machine on the exit syscall or after each
// instruction in step mode, resumes on a rising edge of go, counts retired
// instructions and produces the commit enable for all architectural writes.
module pc_run_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_BITS = 32
) (
  input  logic          clk,
  input  logic          rst,
  pc_run_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // halt_cause encoding: which event parked the machine
  localparam logic CAUSE_STEP    = 1'b0;
  localparam logic CAUSE_SYSCALL = 1'b1;

  logic [0:0]          state;
  logic                halt_cause;
  logic                go_q;
  logic [31:0]         pc_q;
  logic [CNT_BITS-1:0] retired_q;
  logic                misalign_q;
  logic                go_edge;
  logic                retire_now;

  assign go_edge    = bus.go & ~go_q;
  assign retire_now = (state == ST_RUN) & ~bus.halt;

  assign bus.PC       = pc_q;
  assign bus.commit   = retire_now;
  assign bus.running  = (state == ST_RUN);
  assign bus.retired  = retired_q;
  assign bus.misalign = misalign_q;

  // Run/halt sequencing, PC capture, retire counting and misalign tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      halt_cause <= CAUSE_STEP;
      go_q       <= 1'b0;
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      go_q <= bus.go;
      case (state)
        ST_RUN: begin
          if (bus.halt) begin
            state      <= ST_HALTED;
            halt_cause <= CAUSE_SYSCALL;
          end else begin
            pc_q <= {bus.NextPC[31:2], 2'b00};
            if (retired_q != '1) begin
              retired_q <= retired_q + CNT_BITS'(1);
            end
            if (bus.NextPC[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
            end
            if (bus.step_mode) begin
              state      <= ST_HALTED;
              halt_cause <= CAUSE_STEP;
            end
          end
        end
        default: begin
          if (go_edge) begin
            state <= ST_RUN;
            if (halt_cause == CAUSE_SYSCALL) begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Self-checking bench for pc_run_ctrl: a 32-bit counter instance and a 4-bit
// counter instance see identical stimulus; an event-level model of the
// machine is compared against both on every falling clock edge.
module tb_pc_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pc_run_ctrl_if #(.CNT_BITS(32)) bus32 ();
  pc_run_ctrl_if #(.CNT_BITS(4))  bus4 ();

  pc_run_ctrl #(.RESET_PC(32'h0000_0000), .CNT_BITS(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  pc_run_ctrl #(.RESET_PC(32'h0000_0000), .CNT_BITS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  assign bus4.NextPC    = bus32.NextPC;
  assign bus4.halt      = bus32.halt;
  assign bus4.go        = bus32.go;
  assign bus4.step_mode = bus32.step_mode;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Model state: what the machine is doing, not how the RTL encodes it
  bit          m_running  = 1'b1;
  bit          m_syscall  = 1'b0;
  bit          m_go_prev  = 1'b0;
  logic [31:0] m_pc       = 32'h0;
  longint      m_count    = 0;
  bit          m_misalign = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] npc, input logic h,
                               input logic g, input logic s);
    bus32.NextPC    = npc;
    bus32.halt      = h;
    bus32.go        = g;
    bus32.step_mode = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model advance: reset wipes everything; each edge either retires, halts or resumes
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_running  = 1'b1;
      m_syscall  = 1'b0;
      m_go_prev  = 1'b0;
      m_pc       = 32'h0;
      m_count    = 0;
      m_misalign = 1'b0;
    end else begin
      bit rose;
      rose      = bus32.go && !m_go_prev;
      m_go_prev = bus32.go;
      if (m_running) begin
        if (bus32.halt) begin
          m_running = 1'b0;
          m_syscall = 1'b1;
        end else begin
          m_pc    = bus32.NextPC & 32'hFFFF_FFFC;
          m_count = m_count + 1;
          if (bus32.NextPC % 4 != 0) m_misalign = 1'b1;
          if (bus32.step_mode) begin
            m_running = 1'b0;
            m_syscall = 1'b0;
          end
        end
      end else if (rose) begin
        m_running = 1'b1;
        if (m_syscall) m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      longint e32;
      longint e4;
      e32 = (m_count > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count;
      e4  = (m_count > 15) ? 15 : m_count;
      checkOutput("pc",       {32'h0, bus32.PC},       {32'h0, m_pc});
      checkOutput("commit",   {63'h0, bus32.commit},   {63'h0, m_running & ~bus32.halt});
      checkOutput("running",  {63'h0, bus32.running},  {63'h0, m_running});
      checkOutput("misalign", {63'h0, bus32.misalign}, {63'h0, m_misalign});
      checkOutput("retired",  {32'h0, bus32.retired},  e32);
      checkOutput("retired4", {60'h0, bus4.retired},   e4);
      checkOutput("pc4",      {32'h0, bus4.PC},        {32'h0, m_pc});
    end
  end

  initial begin
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1 started = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("lit_reset_pc",      bus32.PC,       32'h0);
    checkOutput("lit_reset_retired", bus32.retired,  32'h0);
    checkOutput("lit_reset_running", bus32.running,  1'b1);
    checkOutput("lit_reset_misal",   bus32.misalign, 1'b0);
    rst = 1'b1;

    // Sequential fetch 0 -> 20
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'(i * 4), 1'b0, 1'b0, 1'b0);
      checkOutput("lit_seq_commit", bus32.commit, 1'b1);
      tick();
      checkOutput("lit_seq_pc", bus32.PC, 32'(i * 4));
    end
    checkOutput("lit_seq_retired", bus32.retired, 32'd5);

    // Advance to 0x20 then hit the exit syscall
    applyStimulus(32'h18, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(32'h1C, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(32'h20, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(32'h24, 1'b1, 1'b0, 1'b0);
    checkOutput("lit_halt_commit", bus32.commit, 1'b0);
    tick();
    checkOutput("lit_halt_pc",      bus32.PC,      32'h20);
    checkOutput("lit_halt_running", bus32.running, 1'b0);
    checkOutput("lit_halt_retired", bus32.retired, 32'd8);

    // go held for three cycles: one resume past the syscall, then normal retire
    applyStimulus(32'h28, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("lit_resume_pc",      bus32.PC,      32'h24);
    checkOutput("lit_resume_running", bus32.running, 1'b1);
    checkOutput("lit_resume_retired", bus32.retired, 32'd8);
    applyStimulus(32'h28, 1'b0, 1'b1, 1'b0); tick();
    applyStimulus(32'h2C, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("lit_after_go_pc", bus32.PC, 32'h2C);
    applyStimulus(32'h30, 1'b0, 1'b0, 1'b0);

    // Resume into another halting instruction with go held high
    applyStimulus(32'h30, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(32'h30, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("lit_rehalt_pc", bus32.PC, 32'h30);
    checkOutput("lit_rehalt_commit", bus32.commit, 1'b0);
    tick();
    checkOutput("lit_rehalt_running", bus32.running, 1'b0);
    tick();
    checkOutput("lit_hold_go_running", bus32.running, 1'b0);
    checkOutput("lit_hold_go_pc",      bus32.PC,      32'h30);

    // Reset, then single-step
    applyStimulus(32'h100, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("lit_step_pc",      bus32.PC,      32'h100);
    checkOutput("lit_step_running", bus32.running, 1'b0);
    checkOutput("lit_step_retired", bus32.retired, 32'd1);
    applyStimulus(32'h200, 1'b0, 1'b1, 1'b1); tick();
    checkOutput("lit_step_resume_pc", bus32.PC, 32'h100);
    checkOutput("lit_step_resume_run", bus32.running, 1'b1);
    applyStimulus(32'h104, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("lit_step2_pc",      bus32.PC,      32'h104);
    checkOutput("lit_step2_running", bus32.running, 1'b0);
    applyStimulus(32'h104, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus(32'h108, 1'b1, 1'b0, 1'b1); tick();
    checkOutput("lit_step_halt_pc", bus32.PC, 32'h104);
    applyStimulus(32'h108, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("lit_step_sys_resume", bus32.PC, 32'h108);
    applyStimulus(32'h10C, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("lit_step_off_running", bus32.running, 1'b1);
    checkOutput("lit_step_off_retired", bus32.retired, 32'd3);

    // Misaligned target
    applyStimulus(32'h13, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("lit_misal_pc",   bus32.PC,       32'h10);
    checkOutput("lit_misal_flag", bus32.misalign, 1'b1);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("lit_misal_sticky", bus32.misalign, 1'b1);

    // Retire 20 more to saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(bus32.PC + 32'd4, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("lit_sat_retired32", bus32.retired, 32'd25);
    checkOutput("lit_sat_retired4",  bus4.retired,  4'hF);

    // Park at 0x40 and reset asynchronously mid-cycle
    applyStimulus(32'h40, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(32'h44, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(32'h44, 1'b0, 1'b1, 1'b0);
    checkOutput("lit_park_pc", bus32.PC, 32'h40);
    rst = 1'b0;
    #1;
    checkOutput("lit_async_pc",      bus32.PC,       32'h0);
    checkOutput("lit_async_retired", bus32.retired,  32'd0);
    checkOutput("lit_async_running", bus32.running,  1'b1);
    checkOutput("lit_async_misal",   bus32.misalign, 1'b0);

    // PC wrap when skipping a syscall at the top of memory
    applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("lit_top_pc", bus32.PC, 32'hFFFF_FFFC);
    applyStimulus(32'h0, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("lit_wrap_pc", bus32.PC, 32'h0);
    applyStimulus(32'h4, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("lit_wrap_next_pc", bus32.PC, 32'h4);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
